mem_responder: RTL and testbench

//  Memory-side responder for the multi-cycle processor's data/instruction bus.

---
 rtl/mem_responder_pkg.sv | 24 ++
 rtl/mem_responder_ram.sv | 43 ++++
 rtl/mem_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//   Shared types and constants for the memory responder.
//   - state_e    : responder FSM states (IDLE, WAIT, RESP)
//   - DATA_W_DEF : default word width (instruction word {opcode4,Rx3,Ry3})
//   - ADDR_W_DEF : default word-address width
//   - CNT_W      : wait-state counter width (WAIT_CYCLES range 0..15)
//   - MMIO_ADDR  : all-ones address of the default geometry, used as the I/O
//                  word when MEM_MMIO_EN is defined
// -----------------------------------------------------------------------------
package mem_responder_pkg;

   localparam int DATA_W_DEF = 10;
   localparam int ADDR_W_DEF = 7;
   localparam int CNT_W      = 4;
   localparam int MMIO_ADDR  = (1 << ADDR_W_DEF) - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage : mem_responder_pkg

// File: rtl/mem_responder_ram.sv
// -----------------------------------------------------------------------------
// resp_ram
//   Single-port synchronous RAM with a registered read port, written so that
//   synthesis maps it onto block RAM.
//   Ports:
//     clock    in   rising-edge clock
//     en_i     in   access strobe; nothing happens when low
//     we_i     in   1 = write wdata_i to addr_i, 0 = read addr_i into rdata_o
//     addr_i   in   word address
//     wdata_i  in   write data
//     rdata_o  out  registered read data; holds until the next read access
// -----------------------------------------------------------------------------
module resp_ram #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 7
) (
   input  logic              clock,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: the array and its output register deliberately have no reset; a
   // reset port on the storage would stop it mapping onto block RAM. The
   // parent masks rdata_q until the first read after reset.
   always_ff @(posedge clock) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule : resp_ram

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the multi-cycle processor bus. A request is
//   captured in IDLE, held for WAIT_CYCLES wait states, then the RAM access is
//   performed on the edge entering RESP and a one-cycle ack is returned.
//   Addresses below ROM_WORDS are write-protected program space.
//
//   Optional feature macro: MEM_MMIO_EN
//     defined   : the all-ones address is an I/O word (leds out, sw in)
//     undefined : leds/sw ports are absent, the all-ones address is plain RAM
//
//   Ports:
//     clock  in   rising-edge clock
//     reset  in   asynchronous, active-high reset
//     req    in   request valid, held by the initiator until ack is seen
//     we     in   1 = write, 0 = read; sampled with req
//     addr   in   word address; sampled with req
//     wdata  in   write data; sampled with req
//     rdata  out  read data; valid with ack, held until the next read completes
//     ack    out  one-cycle completion pulse
//     err    out  pulses with ack when a write hit protected space
//     busy   out  high in any state other than IDLE
//     leds   out  (MEM_MMIO_EN) output port register
//     sw     in   (MEM_MMIO_EN) input switches, sampled on RESP entry
// -----------------------------------------------------------------------------
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int WAIT_CYCLES = 2,
   parameter int ROM_WORDS   = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              err,
   output logic              busy
`ifdef MEM_MMIO_EN
   ,
   output logic [DATA_W-1:0] leds,
   input  logic [DATA_W-1:0] sw
`endif
);

   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [ADDR_W:0]  ROM_LIM   = (ADDR_W + 1)'(ROM_WORDS);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Request copy captured in IDLE; used while the initiator's bus may change.
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              err_q;
   logic              rd_valid_q;  // a read has completed since reset

   // Access actually performed on the RESP-entry edge.
   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic              enter_resp;
   logic              is_prot;
   logic              is_mmio;
   logic              prot_wr;
   logic              ram_en;
   logic [DATA_W-1:0] ram_rdata;

`ifdef MEM_MMIO_EN
   logic              mmio_rd_q;   // last completed read came from the I/O word
   logic [DATA_W-1:0] sw_q;
   logic [DATA_W-1:0] leds_q;
`endif

   // ---------------------------------------------------------------- FSM state
   // NOTE: every clocked assignment uses <= so all registers update from the
   // same pre-edge values, independent of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ----------------------------------------------------------- FSM next state
   // NOTE: defaults first so no path through the case leaves a signal
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------- FSM outputs
   always_comb begin
      ack  = (state_q == RESP);
      busy = (state_q != IDLE);
      err  = (state_q == RESP) && err_q;
`ifdef MEM_MMIO_EN
      if (!rd_valid_q) begin
         rdata = '0;
      end else if (mmio_rd_q) begin
         rdata = sw_q;
      end else begin
         rdata = ram_rdata;
      end
`else
      rdata = rd_valid_q ? ram_rdata : '0;
`endif
   end

   // ------------------------------------------------------ access decode
   // With zero wait states RESP is entered on the capture edge itself, so the
   // live bus is used in IDLE and the captured copy everywhere else.
   always_comb begin
      if (state_q == IDLE) begin
         acc_we    = we;
         acc_addr  = addr;
         acc_wdata = wdata;
      end else begin
         acc_we    = we_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
      end
      enter_resp = (state_d == RESP);
      is_prot    = ({1'b0, acc_addr} < ROM_LIM);
`ifdef MEM_MMIO_EN
      is_mmio    = (acc_addr == {ADDR_W{1'b1}});
`else
      is_mmio    = 1'b0;
`endif
      // The I/O word is never protected, whatever ROM_WORDS is.
      prot_wr    = acc_we && is_prot && !is_mmio;
      ram_en     = enter_resp && !is_mmio && !prot_wr;
   end

   // ------------------------------------------------------ datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         if ((state_q == IDLE) && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         err_q <= enter_resp && prot_wr;
         if (enter_resp && !acc_we) begin
            rd_valid_q <= 1'b1;
         end
      end
   end

`ifdef MEM_MMIO_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mmio_rd_q <= 1'b0;
         sw_q      <= '0;
         leds_q    <= '0;
      end else if (enter_resp) begin
         if (acc_we) begin
            if (is_mmio) begin
               leds_q <= acc_wdata;
            end
         end else begin
            mmio_rd_q <= is_mmio;
            if (is_mmio) begin
               sw_q <= sw;
            end
         end
      end
   end

   assign leds = leds_q;
`endif

   // ------------------------------------------------------ storage
   resp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock   (clock),
      .en_i    (ram_en),
      .we_i    (acc_we),
      .addr_i  (acc_addr),
      .wdata_i (acc_wdata),
      .rdata_o (ram_rdata)
   );

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;
   import mem_responder_pkg::*;

   localparam int DW = DATA_W_DEF;
   localparam int AW = ADDR_W_DEF;
   localparam int WC = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;

   // DUT with WAIT_CYCLES=2
   logic          req = 1'b0, we = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata;
   logic          ack, err, busy;

   // DUT with WAIT_CYCLES=0
   logic          req0 = 1'b0, we0 = 1'b0;
   logic [AW-1:0] addr0 = '0;
   logic [DW-1:0] wdata0 = '0;
   logic [DW-1:0] rdata0;
   logic          ack0, err0, busy0;

`ifdef MEM_MMIO_EN
   logic [DW-1:0] leds, leds0;
   logic [DW-1:0] sw = '0, sw0 = '0;
`endif

   mem_responder #(.WAIT_CYCLES(WC)) dut (
      .clock (clock), .reset (reset), .req (req), .we (we), .addr (addr),
      .wdata (wdata), .rdata (rdata), .ack (ack), .err (err), .busy (busy)
`ifdef MEM_MMIO_EN
      , .leds (leds), .sw (sw)
`endif
   );

   mem_responder #(.WAIT_CYCLES(0)) dut0 (
      .clock (clock), .reset (reset), .req (req0), .we (we0), .addr (addr0),
      .wdata (wdata0), .rdata (rdata0), .ack (ack0), .err (err0), .busy (busy0)
`ifdef MEM_MMIO_EN
      , .leds (leds0), .sw (sw0)
`endif
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // ------------------------------------------------------------ scoreboard
   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
      logic          chk_rd;
   } exp_t;

   exp_t          sb_q[$];
   exp_t          mon_e;
   int            n_vec = 0;
   int            n_bad = 0;
   logic [DW-1:0] seen_rd = '0;  // rdata observed at the latest ack
   logic [DW-1:0] model_rd = '0; // rdata the bench expects to be held

   initial begin
      forever begin
         @(negedge clock);
         if (!reset && ack) begin
            seen_rd = rdata;
            n_vec++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_ack: got ack=1 with nothing outstanding, expected ack=0");
            end else begin
               mon_e = sb_q.pop_front();
               if (err !== mon_e.err) begin
                  n_bad++;
                  $display("FAIL ack_err: got err=%b, expected %b", err, mon_e.err);
               end
               if (mon_e.chk_rd) begin
                  n_vec++;
                  if (rdata !== mon_e.rdata) begin
                     n_bad++;
                     $display("FAIL ack_rdata: got 0x%03h, expected 0x%03h", rdata, mon_e.rdata);
                  end
               end
            end
         end
      end
   end

   // One transaction on the WAIT_CYCLES=2 DUT. Called #1 after an edge with
   // the DUT idle; returns #1 after the edge ending RESP. lat counts edges
   // from the capture edge to the edge on which the initiator samples ack.
   task automatic xact(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp_rd, input logic exp_err, input logic chk_rd,
                       input logic keep, output int lat, output int ack_at);
      exp_t e;
      int   cap;
      bit   got;
      e.rdata = exp_rd; e.err = exp_err; e.chk_rd = chk_rd;
      sb_q.push_back(e);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clock); #1;
      cap = cyc;
      // The DUT must work from its captured copy from here on.
      we = ~w; addr = ~a; wdata = ~d;
      got = 0; lat = -1; ack_at = -1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clock);
         if (ack) begin
            got = 1; lat = cyc - cap + 1; ack_at = cyc;
         end
      end
      if (!got) begin
         n_vec++; n_bad++;
         void'(sb_q.pop_back());
         $display("FAIL ack_timeout: no ack within 40 cycles for addr %0d, expected one", a);
      end
      @(posedge clock); #1;
      if (!keep) req = 1'b0;
      we = 1'b0; addr = '0; wdata = '0;
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_vec += 4;
      if (ack !== 1'b0)  begin n_bad++; $display("FAIL reset_ack: got %b, expected 0", ack); end
      if (err !== 1'b0)  begin n_bad++; $display("FAIL reset_err: got %b, expected 0", err); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      if (rdata !== '0)  begin n_bad++; $display("FAIL reset_rdata: got 0x%03h, expected 0x000", rdata); end
`ifdef MEM_MMIO_EN
      n_vec++;
      if (leds !== '0)   begin n_bad++; $display("FAIL reset_leds: got 0x%03h, expected 0x000", leds); end
`endif
      reset = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_wait_states();
      int lat, at;
      xact(1'b1, 7'd50, 10'h2AA, model_rd, 1'b0, 1'b1, 1'b0, lat, at);
      n_vec++;
      if (lat !== WC + 1) begin n_bad++; $display("FAIL write_latency: got %0d, expected %0d", lat, WC + 1); end
      model_rd = 10'h2AA;
      xact(1'b0, 7'd50, 10'h000, model_rd, 1'b0, 1'b1, 1'b0, lat, at);
      n_vec++;
      if (lat !== WC + 1) begin n_bad++; $display("FAIL read_latency: got %0d, expected %0d", lat, WC + 1); end
   endtask

   task automatic test_reset_mid_wait();
      int lat, at, n_ack;
      xact(1'b1, 7'd40, 10'h0AA, model_rd, 1'b0, 1'b1, 1'b0, lat, at);
      model_rd = 10'h0AA;
      xact(1'b0, 7'd40, 10'h000, model_rd, 1'b0, 1'b1, 1'b0, lat, at);
      // Start a write that must never commit.
      req = 1'b1; we = 1'b1; addr = 7'd40; wdata = 10'h155;
      @(posedge clock); #1;
      n_vec++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_wait_busy: got %b, expected 1", busy); end
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      n_vec += 4;
      if (ack !== 1'b0)  begin n_bad++; $display("FAIL abort_ack: got %b, expected 0", ack); end
      if (err !== 1'b0)  begin n_bad++; $display("FAIL abort_err: got %b, expected 0", err); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b, expected 0", busy); end
      if (rdata !== '0)  begin n_bad++; $display("FAIL abort_rdata: got 0x%03h, expected 0x000", rdata); end
      model_rd = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      n_ack = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (ack) n_ack++;
      end
      n_vec++;
      if (n_ack !== 0) begin n_bad++; $display("FAIL abort_no_ack: got %0d acks, expected 0", n_ack); end
      @(posedge clock); #1;
      model_rd = 10'h0AA;
      xact(1'b0, 7'd40, 10'h000, model_rd, 1'b0, 1'b1, 1'b0, lat, at);
   endtask

   task automatic test_protected();
      int lat, at;
      logic [DW-1:0] rom5;
      // Program-space content is whatever the array holds; learn it first.
      xact(1'b0, 7'd5, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, lat, at);
      rom5 = seen_rd;
      model_rd = rom5;
      xact(1'b1, 7'd5, 10'h3FF, model_rd, 1'b1, 1'b1, 1'b0, lat, at);
      n_vec++;
      if (lat !== WC + 1) begin n_bad++; $display("FAIL prot_latency: got %0d, expected %0d", lat, WC + 1); end
      xact(1'b0, 7'd5, 10'h000, rom5, 1'b0, 1'b1, 1'b0, lat, at);
      // Boundary: last protected word and first writable word.
      xact(1'b1, 7'd31, 10'h0F5, model_rd, 1'b1, 1'b1, 1'b0, lat, at);
      xact(1'b1, 7'd32, 10'h111, model_rd, 1'b0, 1'b1, 1'b0, lat, at);
      model_rd = 10'h111;
      xact(1'b0, 7'd32, 10'h000, model_rd, 1'b0, 1'b1, 1'b0, lat, at);
   endtask

   task automatic test_back_to_back();
      int lat, a1, a2;
      xact(1'b1, 7'd60, 10'h0C3, model_rd, 1'b0, 1'b1, 1'b0, lat, a1);
      xact(1'b1, 7'd61, 10'h13C, model_rd, 1'b0, 1'b1, 1'b0, lat, a1);
      xact(1'b0, 7'd60, 10'h000, 10'h0C3, 1'b0, 1'b1, 1'b1, lat, a1);
      xact(1'b0, 7'd61, 10'h000, 10'h13C, 1'b0, 1'b1, 1'b0, lat, a2);
      model_rd = 10'h13C;
      n_vec++;
      if (a2 - a1 !== WC + 2) begin
         n_bad++; $display("FAIL b2b_spacing: got %0d cycles, expected %0d", a2 - a1, WC + 2);
      end
   endtask

   task automatic test_zero_wait();
      int nb;
      // Write on the WAIT_CYCLES=0 instance: ack right after the capture edge.
      req0 = 1'b1; we0 = 1'b1; addr0 = 7'd60; wdata0 = 10'h1C7;
      @(posedge clock); #1;
      n_vec += 3;
      if (ack0 !== 1'b1)  begin n_bad++; $display("FAIL zw_write_ack: got %b, expected 1", ack0); end
      if (busy0 !== 1'b1) begin n_bad++; $display("FAIL zw_write_busy: got %b, expected 1", busy0); end
      if (err0 !== 1'b0)  begin n_bad++; $display("FAIL zw_write_err: got %b, expected 0", err0); end
      @(posedge clock); #1;
      req0 = 1'b0; we0 = 1'b0;
      // Read back and count busy cycles around it.
      nb = 0;
      req0 = 1'b1; addr0 = 7'd60;
      @(negedge clock); if (busy0) nb++;
      @(negedge clock); if (busy0) nb++;
      n_vec += 2;
      if (ack0 !== 1'b1) begin n_bad++; $display("FAIL zw_read_ack: got %b, expected 1", ack0); end
      if (rdata0 !== 10'h1C7) begin n_bad++; $display("FAIL zw_read_rdata: got 0x%03h, expected 0x1c7", rdata0); end
      @(posedge clock); #1;
      req0 = 1'b0; addr0 = '0;
      @(negedge clock); if (busy0) nb++;
      n_vec++;
      if (ack0 !== 1'b0) begin n_bad++; $display("FAIL zw_ack_pulse: got %b, expected 0", ack0); end
      @(negedge clock); if (busy0) nb++;
      n_vec++;
      if (nb !== 1) begin n_bad++; $display("FAIL zw_busy_cycles: got %0d, expected 1", nb); end
      @(posedge clock); #1;
   endtask

   task automatic test_top_word();
      int lat, at;
      logic [AW-1:0] top_a;
      top_a = AW'(MMIO_ADDR);
`ifdef MEM_MMIO_EN
      xact(1'b1, top_a, 10'h0F0, model_rd, 1'b0, 1'b1, 1'b0, lat, at);
      n_vec++;
      if (leds !== 10'h0F0) begin n_bad++; $display("FAIL mmio_leds: got 0x%03h, expected 0x0f0", leds); end
      sw = 10'h123;
      model_rd = 10'h123;
      xact(1'b0, top_a, 10'h000, model_rd, 1'b0, 1'b1, 1'b0, lat, at);
      sw = 10'h3C3;
      @(negedge clock);
      n_vec += 2;
      if (rdata !== 10'h123) begin n_bad++; $display("FAIL mmio_rdata_hold: got 0x%03h, expected 0x123", rdata); end
      if (leds !== 10'h0F0)  begin n_bad++; $display("FAIL mmio_leds_hold: got 0x%03h, expected 0x0f0", leds); end
      @(posedge clock); #1;
`else
      xact(1'b1, top_a, 10'h0F0, model_rd, 1'b0, 1'b1, 1'b0, lat, at);
      model_rd = 10'h0F0;
      xact(1'b0, top_a, 10'h000, model_rd, 1'b0, 1'b1, 1'b0, lat, at);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_wait_states();
      test_reset_mid_wait();
      test_protected();
      test_back_to_back();
      test_zero_wait();
      test_top_word();
      repeat (4) @(posedge clock);
      n_vec++;
      if (sb_q.size() !== 0) begin
         n_bad++; $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_mem_responder
